// File: rtl/xor_cipher_lanes.sv
// xor_cipher_lanes: LANES independent 16-bit Fibonacci-LFSR XOR ciphers.
// Seeds are loaded through a serial daisy chain (cfg_i -> lanes -> cfg_o).
// An IDLE/LOAD/RUN FSM gates stepping. A one-cycle encrypt/decrypt path
// produces e = din ^ ks and d = cin ^ ks for each lane.
// Optional feature: define XOR_CIPHER_HEARTBEAT_EN to build the liveness
// heartbeat counter. Without it, heartbeat is tied low.

// One cipher lane. It holds the LFSR state and the registered e/d bits.
module xor_cipher_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,     // seed chain shift
  input  logic fix_zero,  // LOAD->RUN: escape the all-zero lockup state
  input  logic step,      // accepted beat
  input  logic sin,
  input  logic din,
  input  logic cin,
  output logic ks,        // keystream bit, also the chain output of this lane
  output logic e,
  output logic d
);
  logic [15:0] s;

  assign ks = s[15];

  // LFSR state and result registers; shift/fix/step are mutually exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 16'h0000;
      e <= 1'b0;
      d <= 1'b0;
    end else begin
      if (shift)
        s <= {s[14:0], sin};
      else if (fix_zero && (s == 16'h0000))
        s <= 16'h0001;
      else if (step)
        s <= {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      if (step) begin
        e <= din ^ s[15];
        d <= cin ^ s[15];
      end
    end
  end
endmodule

module xor_cipher_lanes #(
  parameter int LANES  = 2,
  parameter int HB_DIV = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_i,
  output logic             cfg_o,
  input  logic             din_valid,
  input  logic [LANES-1:0] din,
  input  logic [LANES-1:0] cin,
  output logic [LANES-1:0] e,
  output logic [LANES-1:0] d,
  output logic             dout_valid,
  output logic             heartbeat
);
  localparam int FULL = 16 * LANES;
  localparam int CW   = $clog2(FULL + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LANES:0] chain;
  logic          shift, fix_zero, step;

  // cfg_en always wins over din_valid, so a colliding beat is dropped
  assign shift    = (state == LOAD) && cfg_en;
  assign fix_zero = (state == LOAD) && !cfg_en && (cnt == CW'(FULL));
  assign step     = (state == RUN)  && din_valid && !cfg_en;

  assign chain[0] = cfg_i;
  assign cfg_o    = chain[LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    xor_cipher_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift    (shift),
      .fix_zero (fix_zero),
      .step     (step),
      .sin      (chain[i]),
      .din      (din[i]),
      .cin      (cin[i]),
      .ks       (chain[i+1]),
      .e        (e[i]),
      .d        (d[i])
    );
  end

  // Load FSM; RUN is only reachable after a complete 16*LANES-bit reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_en) state <= LOAD;
        LOAD: begin
          if (cfg_en) begin
            if (cnt != CW'(FULL)) cnt <= cnt + 1'b1;
          end else begin
            state <= (cnt == CW'(FULL)) ? RUN : IDLE;
            cnt   <= '0;
          end
        end
        RUN:  if (cfg_en) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  // Output strobe, aligned with the registered e/d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_valid <= 1'b0;
    else        dout_valid <= step;
  end

`ifdef XOR_CIPHER_HEARTBEAT_EN
  logic [HB_DIV-1:0] hb_cnt;

  // Free-running divider; heartbeat flips on every wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) heartbeat <= ~heartbeat;
    end
  end
`else
  assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_xor_cipher_lanes.sv
// Directed bench for xor_cipher_lanes with LANES=2 and HB_DIV=4.
module tb_xor_cipher_lanes;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_en = 1'b0, cfg_i = 1'b0, cfg_o;
  logic       din_valid = 1'b0;
  logic [1:0] din = '0, cin = '0, e, d;
  logic       dout_valid, heartbeat;
  int         n_chk = 0, n_pass = 0;

  xor_cipher_lanes #(.LANES(2), .HB_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .din_valid(din_valid), .din(din), .cin(cin), .e(e), .d(d),
    .dout_valid(dout_valid), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    cfg_en = 0; cfg_i = 0; din_valid = 0; din = '0; cin = '0;
    rst_n = 0; tick; tick; rst_n = 1;
  endtask

  // Enter LOAD, shift n bits MSB-first from bits[31], then drop cfg_en
  task automatic load(input logic [31:0] bits, input int n);
    cfg_en = 1; tick;
    for (int i = 0; i < n; i++) begin cfg_i = bits[31-i]; tick; end
    cfg_en = 0; cfg_i = 0; tick;
  endtask

  task automatic beat(input logic [1:0] pd, input logic [1:0] pc);
    din_valid = 1; din = pd; cin = pc; tick; din_valid = 0;
  endtask

  task automatic test_reset;
    #1 rst_n = 0; #2;
    n_chk++; if ({e, d, dout_valid, cfg_o, heartbeat} !== 7'b0)
      $display("FAIL reset_outputs: got %b exp 0000000", {e, d, dout_valid, cfg_o, heartbeat});
    else n_pass++;
    tick; rst_n = 1;
  endtask

  task automatic test_heartbeat;
    logic exp;
    do_reset;
    for (int k = 1; k <= 40; k++) begin
      tick;
`ifdef XOR_CIPHER_HEARTBEAT_EN
      exp = ((k / 16) % 2) == 1;
`else
      exp = 1'b0;
`endif
      n_chk++; if (heartbeat !== exp)
        $display("FAIL heartbeat_k%0d: got %b exp %b", k, heartbeat, exp);
      else n_pass++;
    end
  endtask

  task automatic test_basic;
    do_reset;
    load(32'h8000_8000, 32);
    n_chk++; if (cfg_o !== 1'b1) $display("FAIL basic_cfg_o: got %b exp 1", cfg_o); else n_pass++;
    beat(2'b11, 2'b00);
    n_chk++; if ({dout_valid, e, d} !== 5'b1_00_11)
      $display("FAIL basic_beat1: got %b exp 10011", {dout_valid, e, d}); else n_pass++;
    beat(2'b11, 2'b01);
    n_chk++; if ({dout_valid, e, d} !== 5'b1_11_01)
      $display("FAIL basic_beat2: got %b exp 11101", {dout_valid, e, d}); else n_pass++;
    tick;
    n_chk++; if ({dout_valid, e, d} !== 5'b0_11_01)
      $display("FAIL basic_hold: got %b exp 01101", {dout_valid, e, d}); else n_pass++;
  endtask

  // Zero seed forced to 0001; keystream bit n-1 of the constant is the bit for beat n
  task automatic test_zero_seed;
    logic [31:0] ks_exp;
    int bad;
    ks_exp = 32'hB400_8000;
    bad = 0;
    do_reset;
    load(32'h0000_0000, 32);
    for (int n = 0; n < 32; n++) begin
      beat(2'b00, 2'b01);
      n_chk++;
      if ({e, d} !== {ks_exp[n], ks_exp[n], ks_exp[n], ~ks_exp[n]})
        $display("FAIL zero_seed_beat%0d: got e=%b d=%b exp ks=%b", n + 1, e, d, ks_exp[n]);
      else n_pass++;
    end
  endtask

  task automatic test_partial;
    do_reset;
    load(32'hFFFF_FFFF, 20);
    for (int i = 0; i < 3; i++) begin
      beat(2'b11, 2'b11);
      n_chk++; if ({dout_valid, e, d} !== 5'b0)
        $display("FAIL partial_beat%0d: got %b exp 00000", i, {dout_valid, e, d}); else n_pass++;
    end
  endtask

  task automatic test_priority;
    logic [31:0] cap, nseed;
    nseed = 32'h8000_8000;
    do_reset;
    load(32'hA5C3_1234, 32);
    cfg_en = 1; din_valid = 1; din = 2'b11; cin = 2'b11; tick; din_valid = 0;
    n_chk++; if ({dout_valid, e} !== 3'b0)
      $display("FAIL prio_drop: got %b exp 000", {dout_valid, e}); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      cap[31-i] = cfg_o; cfg_i = nseed[31-i]; tick;
    end
    cfg_en = 0; cfg_i = 0; tick;
    n_chk++; if (cap !== 32'hA5C3_1234)
      $display("FAIL prio_chain_out: got %h exp a5c31234", cap); else n_pass++;
    beat(2'b11, 2'b00);
    n_chk++; if ({dout_valid, e} !== 3'b1_00)
      $display("FAIL prio_reload: got %b exp 100", {dout_valid, e}); else n_pass++;
    // Partial reload from RUN drops back to IDLE
    cfg_en = 1; tick;
    for (int i = 0; i < 5; i++) begin cfg_i = 1; tick; end
    cfg_en = 0; cfg_i = 0; tick;
    beat(2'b11, 2'b11);
    n_chk++; if ({dout_valid, e} !== 3'b0_00)
      $display("FAIL prio_partial_idle: got %b exp 000", {dout_valid, e}); else n_pass++;
  endtask

  task automatic test_roundtrip;
    logic [1:0] pat [8];
    logic [1:0] ct  [8];
    pat = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
    do_reset;
    load(32'hBEEF_0513, 32);
    for (int i = 0; i < 8; i++) begin beat(pat[i], 2'b00); ct[i] = e; end
    #2 rst_n = 0; #1;
    n_chk++; if ({dout_valid, e, d} !== 5'b0)
      $display("FAIL async_reset: got %b exp 00000", {dout_valid, e, d}); else n_pass++;
    tick; rst_n = 1;
    load(32'hBEEF_0513, 32);
    for (int i = 0; i < 8; i++) begin
      beat(2'b00, ct[i]);
      n_chk++; if ({dout_valid, d} !== {1'b1, pat[i]})
        $display("FAIL roundtrip_%0d: got v=%b d=%b exp v=1 d=%b", i, dout_valid, d, pat[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_heartbeat;
    test_basic;
    test_zero_seed;
    test_partial;
    test_priority;
    test_roundtrip;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
